// File: rtl/vec_dot_scalar_pkg.sv
// Shared RLS helpers: state encoding, constant clog2 and the wide-to-narrow
// saturation used when a full-precision accumulator is returned to WIDTH bits.
package vec_dot_scalar_pkg;

   localparam int SAT_MAXW = 256;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      FINISH
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

   // Callers sign-extend into SAT_MAXW bits and keep the low 'width' bits of the result.
   function automatic logic signed [SAT_MAXW-1:0] saturate(input logic signed [SAT_MAXW-1:0] value,
                                                           input int width);
      logic signed [SAT_MAXW-1:0] hi;
      logic signed [SAT_MAXW-1:0] lo;
      hi = (SAT_MAXW'(1) <<< (width - 1)) - SAT_MAXW'(1);
      lo = ~hi;
      if (value > hi) begin
         return hi;
      end
      if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/vec_dot_scalar_if.sv
// Start/valid handshake and operand bus between a producer and vec_dot_scalar.
interface vec_dot_scalar_if #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 16
);
   logic                    start;
   logic [WIDTH*SIZE-1:0]   a;
   logic [WIDTH*SIZE-1:0]   b;
   logic                    busy;
   logic                    valid;
   logic [WIDTH-1:0]        y;

   modport master (output start, a, b, input busy, valid, y);
   modport slave  (input start, a, b, output busy, valid, y);
endinterface

// File: rtl/vec_dot_partial.sv
// Combinational lane array: full-precision sum of COMBSIZE signed products.
module vec_dot_partial
   import vec_dot_scalar_pkg::*;
#(
   parameter int  WIDTH    = 32,
   parameter int  COMBSIZE = 4,
   localparam int PW       = 2 * WIDTH + clog2(COMBSIZE)
) (
   input  logic [WIDTH*COMBSIZE-1:0] a_i,
   input  logic [WIDTH*COMBSIZE-1:0] b_i,
   output logic signed [PW-1:0]      sum_o
);

   localparam int PRODW = 2 * WIDTH;

   logic signed [PRODW-1:0] prods [COMBSIZE];

   for (genvar j = 0; j < COMBSIZE; j++) begin : g_lane
      logic signed [PRODW-1:0] aExt;
      logic signed [PRODW-1:0] bExt;
      assign aExt     = PRODW'($signed(a_i[WIDTH*j +: WIDTH]));
      assign bExt     = PRODW'($signed(b_i[WIDTH*j +: WIDTH]));
      assign prods[j] = aExt * bExt;
   end

   always_comb begin
      sum_o = '0;
      for (int j = 0; j < COMBSIZE; j++) begin
         sum_o = sum_o + PW'(prods[j]);
      end
   end

endmodule

// File: rtl/vec_dot_scalar.sv
// Time-multiplexed signed dot product: y = sat((sum a_i*b_i) >>> FRAC), processing
// COMBSIZE element pairs per cycle from operands latched when start is accepted.
module vec_dot_scalar
   import vec_dot_scalar_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int SIZE     = 16,
   parameter int COMBSIZE = 4,
   parameter int FRAC     = 0
) (
   input  logic             clk,
   input  logic             reset,
   vec_dot_scalar_if.slave  bus
);

   localparam int N    = SIZE / COMBSIZE;
   localparam int IDXW = (N > 1) ? clog2(N) : 1;
   localparam int ACCW = 2 * WIDTH + clog2(SIZE);
   localparam int PW   = 2 * WIDTH + clog2(COMBSIZE);
   localparam int CW   = WIDTH * COMBSIZE;
   localparam int VW   = WIDTH * SIZE;
   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

   if (SIZE % COMBSIZE != 0) begin : g_size_check
      $error("vec_dot_scalar: SIZE must be a multiple of COMBSIZE");
   end

   state_t                  state_q;
   logic [VW-1:0]           aLat_q;
   logic [VW-1:0]           bLat_q;
   logic signed [ACCW-1:0]  acc_q;
   logic [IDXW-1:0]         idx_q;
   logic                    busy_q;
   logic                    valid_q;
   logic [WIDTH-1:0]        y_q;

   logic [CW-1:0]           aChunk;
   logic [CW-1:0]           bChunk;
   logic signed [PW-1:0]    partSum;
   logic signed [ACCW-1:0]  shifted;

   // Select the chunk of latched operands that the lane array works on this cycle.
   always_comb begin
      aChunk = aLat_q[idx_q*CW +: CW];
      bChunk = bLat_q[idx_q*CW +: CW];
   end

   vec_dot_partial #(
      .WIDTH    (WIDTH),
      .COMBSIZE (COMBSIZE)
   ) u_partial (
      .a_i   (aChunk),
      .b_i   (bChunk),
      .sum_o (partSum)
   );

   assign shifted = acc_q >>> FRAC;

   // busy covers the accumulation cycles only, so it drops as FINISH is entered
   // and can never coincide with the valid pulse that FINISH produces.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         y_q     <= '0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  aLat_q  <= bus.a;
                  bLat_q  <= bus.b;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               acc_q <= acc_q + ACCW'(partSum);
               idx_q <= idx_q + IDXW'(1);
               if (idx_q == LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= FINISH;
               end
            end
            FINISH: begin
               y_q     <= WIDTH'(saturate(SAT_MAXW'(shifted), WIDTH));
               valid_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.valid = valid_q;
   assign bus.y     = y_q;

endmodule

// File: tb/tb_vec_dot_scalar.sv
// Directed bench for vec_dot_scalar: integer, fixed-point, single-chunk and handshake cases.
module tb_vec_dot_scalar;

   localparam int W  = 32;
   localparam int S  = 16;
   localparam int VW = W * S;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   vec_dot_scalar_if #(.WIDTH(W), .SIZE(S)) ifA ();
   vec_dot_scalar_if #(.WIDTH(W), .SIZE(S)) ifB ();
   vec_dot_scalar_if #(.WIDTH(W), .SIZE(S)) ifC ();

   vec_dot_scalar #(.WIDTH(W), .SIZE(S), .COMBSIZE(4), .FRAC(0)) dutA (
      .clk (clk), .reset (reset), .bus (ifA.slave));
   vec_dot_scalar #(.WIDTH(W), .SIZE(S), .COMBSIZE(4), .FRAC(16)) dutB (
      .clk (clk), .reset (reset), .bus (ifB.slave));
   vec_dot_scalar #(.WIDTH(W), .SIZE(S), .COMBSIZE(16), .FRAC(0)) dutC (
      .clk (clk), .reset (reset), .bus (ifC.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Last-resort guard so a stuck run still ends with a report.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [VW-1:0] splat(input logic [W-1:0] v);
      logic [VW-1:0] r;
      for (int i = 0; i < S; i++) r[W*i +: W] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] ramp();
      logic [VW-1:0] r;
      for (int i = 0; i < S; i++) r[W*i +: W] = W'(i);
      return r;
   endfunction

   task automatic setInputs(input int sel, input logic st, input logic [VW-1:0] av, input logic [VW-1:0] bv);
      case (sel)
         0: begin ifA.start = st; ifA.a = av; ifA.b = bv; end
         1: begin ifB.start = st; ifB.a = av; ifB.b = bv; end
         default: begin ifC.start = st; ifC.a = av; ifC.b = bv; end
      endcase
   endtask

   function automatic logic getBusy(input int sel);
      case (sel)
         0: return ifA.busy;
         1: return ifB.busy;
         default: return ifC.busy;
      endcase
   endfunction

   function automatic logic getValid(input int sel);
      case (sel)
         0: return ifA.valid;
         1: return ifB.valid;
         default: return ifC.valid;
      endcase
   endfunction

   function automatic logic [W-1:0] getY(input int sel);
      case (sel)
         0: return ifA.y;
         1: return ifB.y;
         default: return ifC.y;
      endcase
   endfunction

   // Start one operation, optionally swap operands after acceptance and pulse start mid-run.
   task automatic runOp(input int sel, input logic [VW-1:0] av, input logic [VW-1:0] bv,
                        input logic [VW-1:0] av2, input logic [VW-1:0] bv2, input bit midStart,
                        output logic [W-1:0] yv, output int lat, output int busyCnt, output bit timedOut);
      setInputs(sel, 1'b1, av, bv);
      @(posedge clk); #1;
      setInputs(sel, 1'b0, av2, bv2);
      lat      = 0;
      busyCnt  = getBusy(sel) ? 1 : 0;
      timedOut = 1'b1;
      yv       = '0;
      for (int k = 0; k < 20; k++) begin
         setInputs(sel, midStart && (k == 1), av2, bv2);
         @(posedge clk); #1;
         lat++;
         if (getValid(sel)) begin
            yv       = getY(sel);
            timedOut = 1'b0;
            break;
         end
         if (getBusy(sel)) busyCnt++;
      end
      setInputs(sel, 1'b0, av2, bv2);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int s = 0; s < 3; s++) setInputs(s, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (getBusy(s) !== 1'b0 || getValid(s) !== 1'b0 || getY(s) !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state dut%0d: busy=%b valid=%b y=%h, required busy=0 valid=0 y=0",
                     s, getBusy(s), getValid(s), getY(s));
         end
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_all_ones();
      logic [W-1:0] yv;
      int lat, busyCnt;
      bit to;
      runOp(0, splat(1), splat(1), splat(1), splat(1), 1'b0, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'd16) begin
         errors++;
         $display("[TB] FAIL all_ones_y: got %0d (timeout=%0b), required 16", yv, to);
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("[TB] FAIL all_ones_latency: got %0d edges, required 5", lat);
      end
      checks++;
      if (busyCnt !== 4) begin
         errors++;
         $display("[TB] FAIL all_ones_busy_cycles: got %0d, required 4", busyCnt);
      end
      @(posedge clk); #1;
      checks++;
      if (ifA.valid !== 1'b0 || ifA.y !== 32'd16) begin
         errors++;
         $display("[TB] FAIL valid_single_pulse: valid=%b y=%0d, required valid=0 y=16", ifA.valid, ifA.y);
      end
   endtask

   task automatic test_ramp();
      logic [W-1:0] yv;
      int lat, busyCnt;
      bit to;
      runOp(0, ramp(), ramp(), ramp(), ramp(), 1'b0, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'd1240) begin
         errors++;
         $display("[TB] FAIL ramp_y: got %0d (timeout=%0b), required 1240", yv, to);
      end
   endtask

   task automatic test_single_chunk();
      logic [W-1:0] yv;
      int lat, busyCnt;
      bit to;
      runOp(2, ramp(), ramp(), ramp(), ramp(), 1'b0, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'd1240) begin
         errors++;
         $display("[TB] FAIL single_chunk_y: got %0d (timeout=%0b), required 1240", yv, to);
      end
      checks++;
      if (lat !== 2 || busyCnt !== 1) begin
         errors++;
         $display("[TB] FAIL single_chunk_timing: latency=%0d busy=%0d, required latency=2 busy=1", lat, busyCnt);
      end
   endtask

   task automatic test_fixed_point();
      logic [W-1:0] yv;
      logic [VW-1:0] minusOne;
      int lat, busyCnt;
      bit to;
      runOp(1, splat(32'h0001_0000), splat(32'h0000_8000), splat(32'h0001_0000), splat(32'h0000_8000),
            1'b0, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'h0008_0000) begin
         errors++;
         $display("[TB] FAIL fixed_pos: got %h (timeout=%0b), required 00080000", yv, to);
      end
      runOp(1, splat(32'hFFFE_0000), splat(32'h0003_0000), splat(32'hFFFE_0000), splat(32'h0003_0000),
            1'b0, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'hFFA0_0000) begin
         errors++;
         $display("[TB] FAIL fixed_neg: got %h (timeout=%0b), required ffa00000", yv, to);
      end
      // A sum of -1 must shift arithmetically to -1, not to a large positive value.
      minusOne = '0;
      minusOne[W-1:0] = 32'hFFFF_FFFF;
      runOp(1, minusOne, splat(1), minusOne, splat(1), 1'b0, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'hFFFF_FFFF) begin
         errors++;
         $display("[TB] FAIL fixed_arith_shift: got %h (timeout=%0b), required ffffffff", yv, to);
      end
   endtask

   task automatic test_saturation();
      logic [W-1:0] yv;
      int lat, busyCnt;
      bit to;
      runOp(0, splat(32'h7FFF_FFFF), splat(32'h7FFF_FFFF), splat(32'h7FFF_FFFF), splat(32'h7FFF_FFFF),
            1'b0, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'h7FFF_FFFF) begin
         errors++;
         $display("[TB] FAIL sat_pos: got %h (timeout=%0b), required 7fffffff", yv, to);
      end
      runOp(0, splat(32'h8000_0000), splat(32'h7FFF_FFFF), splat(32'h8000_0000), splat(32'h7FFF_FFFF),
            1'b0, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'h8000_0000) begin
         errors++;
         $display("[TB] FAIL sat_neg: got %h (timeout=%0b), required 80000000", yv, to);
      end
   endtask

   task automatic test_latched_inputs();
      logic [W-1:0] yv;
      int lat, busyCnt, extra;
      bit to;
      runOp(0, ramp(), ramp(), splat(1), splat(1), 1'b1, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'd1240) begin
         errors++;
         $display("[TB] FAIL latched_inputs_y: got %0d (timeout=%0b), required 1240", yv, to);
      end
      extra = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (ifA.valid) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("[TB] FAIL start_while_busy: got %0d extra valid pulses, required 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, nValid, overlap, badY;
      int times [3];
      setInputs(0, 1'b1, splat(2), splat(3));
      cyc = 0; nValid = 0; overlap = 0; badY = 0;
      for (int k = 0; k < 3; k++) times[k] = -1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (ifA.valid && ifA.busy) overlap++;
         if (ifA.valid) begin
            if (nValid < 3) times[nValid] = cyc;
            if (ifA.y !== 32'd96) badY++;
            nValid++;
         end
      end
      setInputs(0, 1'b0, splat(2), splat(3));
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (times[0] !== 6 || times[1] !== 12 || times[2] !== 18 || nValid !== 3) begin
         errors++;
         $display("[TB] FAIL back_to_back_timing: valid at %0d,%0d,%0d count %0d, required 6,12,18 count 3",
                  times[0], times[1], times[2], nValid);
      end
      checks++;
      if (badY !== 0) begin
         errors++;
         $display("[TB] FAIL back_to_back_y: %0d results differ from 96, required 0", badY);
      end
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("[TB] FAIL valid_busy_overlap: got %0d overlapping cycles, required 0", overlap);
      end
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] yv;
      int lat, busyCnt;
      bit to;
      checks++;
      if (ifA.y !== 32'd96) begin
         errors++;
         $display("[TB] FAIL y_hold: got %0d, required 96", ifA.y);
      end
      setInputs(0, 1'b1, splat(5), splat(5));
      @(posedge clk); #1;
      setInputs(0, 1'b0, splat(5), splat(5));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ifA.busy !== 1'b0 || ifA.valid !== 1'b0 || ifA.y !== '0) begin
         errors++;
         $display("[TB] FAIL reset_abort: busy=%b valid=%b y=%0d, required busy=0 valid=0 y=0",
                  ifA.busy, ifA.valid, ifA.y);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      runOp(0, splat(1), splat(1), splat(1), splat(1), 1'b0, yv, lat, busyCnt, to);
      checks++;
      if (to || yv !== 32'd16 || lat !== 5) begin
         errors++;
         $display("[TB] FAIL after_abort: got y=%0d latency=%0d (timeout=%0b), required y=16 latency=5",
                  yv, lat, to);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_all_ones();
      test_ramp();
      test_single_chunk();
      test_fixed_point();
      test_saturation();
      test_latched_inputs();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
